// File: rtl/uart_rx_fifo.sv
// 8-bit async-serial receiver (start, 8 data LSB-first, optional even parity, stop) feeding a show-ahead FIFO.
// Define UART_RX_PARITY_EN to add the parity bit and a live parity_error; otherwise parity_error is tied 0.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | line idle, waiting for a falling edge on rxs
// S_START  | half-bit wait, confirm start bit at its midpoint
// S_DATA   | sample 8 data bits mid-bit, shift in LSB-first
// S_PARITY | sample the even-parity bit (UART_RX_PARITY_EN only)
// S_STOP   | sample stop bit, decide push / frame / parity / overrun
// S_BREAK  | stop bit was 0, wait for the line to return high
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               uart_rx_input,
    output logic [7:0]                         rx_data,
    output logic                               rx_valid,
    input  logic                               rx_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    rx_count,
    output logic                               frame_error,
    output logic                               overrun,
    output logic                               parity_error
);

    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = $clog2(FIFO_DEPTH + 1);

    localparam logic [CW-1:0]   HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]   BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CNTW-1:0] FULL_CNT  = CNTW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t          state_q, state_d;
    logic            sync1_q, sync2_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
    logic            par_q, par_d;
    logic            parity_err_q, parity_err_d;
`endif

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [7:0]      mem_d [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic [7:0]      rx_data_q, rx_data_d;

    logic            rxs;
    logic            push;
    logic            pop;
    logic            full;
    logic            parity_bad;

    assign rxs  = sync2_q;
    assign pop  = (count_q != '0) && rx_ready;
    assign full = (count_q == FULL_CNT);

`ifdef UART_RX_PARITY_EN
    assign parity_bad = ^{shift_q, par_q};
`else
    assign parity_bad = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        push        = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d        = par_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (!rxs) begin
                    state_d = S_START;
                    cnt_d   = HALF_LOAD;
                end
            end
            S_START: begin
                if (cnt_q == '0) begin
                    if (rxs) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DATA;
                        cnt_d     = BIT_LOAD;
                        bit_cnt_d = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    shift_d   = {rxs, shift_q[7:1]};
                    cnt_d     = BIT_LOAD;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == '0) begin
                    par_d   = rxs;
                    cnt_d   = BIT_LOAD;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == '0) begin
                    // Decided mid stop bit so a back-to-back start edge is not missed.
                    state_d = S_IDLE;
                    if (!rxs) begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end else if (parity_bad) begin
`ifdef UART_RX_PARITY_EN
                        parity_err_d = 1'b1;
`endif
                    end else if (full && !pop) begin
                        overrun_d = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_BREAK: begin
                if (rxs) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rx_data_d = rx_data_q;
        if (push) begin
            mem_d[wr_ptr_q] = shift_q;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
        // Registered head: when the FIFO drains, the last byte stays visible.
        if (count_d != '0) begin
            if ((count_q == '0) || ((count_q == CNTW'(1)) && pop)) begin
                rx_data_d = shift_q;
            end else begin
                rx_data_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            cnt_q       <= '0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rx_data_q   <= 8'h00;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            state_q     <= state_d;
            sync1_q     <= uart_rx_input;
            sync2_q     <= sync1_q;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rx_data_q   <= rx_data_d;
            mem_q       <= mem_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_error = parity_err_q;
`else
    assign parity_error = 1'b0;
`endif

    assign rx_data     = rx_data_q;
    assign rx_valid    = (count_q != '0);
    assign rx_count    = count_q;
    assign frame_error = frame_err_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at CLKS_PER_BIT=16, FIFO_DEPTH=4.
// Honors UART_RX_PARITY_EN when compiled with it; default build expects parity_error to stay 0.
module tb_uart_rx_fifo;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 171;
`else
    localparam int LAT = 155;
`endif

    logic       clock;
    logic       reset;
    logic       line;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [2:0] rx_count;
    logic       frame_error;
    logic       overrun;
    logic       parity_error;

    int checks   = 0;
    int failures = 0;

    int         cyc = 0;
    int         fe_n = 0, ov_n = 0, pe_n = 0;
    int         rise_cyc = -1;
    logic       prev_valid = 1'b0;
    logic [7:0] popped [64];
    int         pop_n = 0;
    int         rd_idx = 0;
    int         start_cyc = 0;
    int         fe_base, ov_base, pe_base;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clock         (clock),
        .reset         (reset),
        .uart_rx_input (line),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .rx_count      (rx_count),
        .frame_error   (frame_error),
        .overrun       (overrun),
        .parity_error  (parity_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (frame_error)  fe_n++;
        if (overrun)      ov_n++;
        if (parity_error) pe_n++;
        if (rx_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = rx_valid;
        if (rx_valid && rx_ready && pop_n < 64) begin
            popped[pop_n] = rx_data;
            pop_n++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_pop(input string tag, input logic [7:0] exp);
        chk(tag, {24'h0, popped[rd_idx]}, {24'h0, exp});
        rd_idx++;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic drive_bit(input logic v);
        line = v;
        tick(CPB);
    endtask

    // Entered and left at posedge+1. rdy_at_stop raises rx_ready for the stop-sample cycle only.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                              input logic par_flip, input logic rdy_at_stop);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ par_flip);
`endif
        line = stop_bit;
        for (int i = 0; i < CPB; i++) begin
            if (rdy_at_stop && i == 10) rx_ready = 1'b1;
            if (rdy_at_stop && i == 11) rx_ready = 1'b0;
            tick(1);
        end
        line = 1'b1;
    endtask

    task automatic snap();
        fe_base = fe_n;
        ov_base = ov_n;
        pe_base = pe_n;
    endtask

    initial begin
        reset    = 1'b1;
        line     = 1'b1;
        rx_ready = 1'b0;
        tick(3);
        chk("rst_valid", {31'h0, rx_valid}, 32'h0);
        chk("rst_count", {29'h0, rx_count}, 32'h0);
        chk("rst_data",  {24'h0, rx_data},  32'h0);
        chk("rst_pulses", {29'h0, frame_error, overrun, parity_error}, 32'h0);
        reset = 1'b0;
        tick(5);

        // 0xA5 with consumer ready
        snap();
        rx_ready = 1'b1;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        tick(4);
        chk("a5_latency", rise_cyc - start_cyc, LAT);
        chk("a5_pops", pop_n, 1);
        next_pop("a5_data", 8'hA5);
        chk("a5_count", {29'h0, rx_count}, 32'h0);
        chk("a5_nopulse", (fe_n - fe_base) + (ov_n - ov_base) + (pe_n - pe_base), 0);

        // 5-cycle glitch
        snap();
        line = 1'b0;
        tick(5);
        line = 1'b1;
        tick(40);
        chk("glitch_count", {29'h0, rx_count}, 32'h0);
        chk("glitch_pops", pop_n, 1);
        chk("glitch_nopulse", (fe_n - fe_base) + (ov_n - ov_base) + (pe_n - pe_base), 0);

        // 0x3C with bad stop, line held low long enough to look like further frames
        snap();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        line = 1'b0;
        tick(200);
        line = 1'b1;
        tick(20);
        chk("fe_pulses", fe_n - fe_base, 1);
        chk("fe_count", {29'h0, rx_count}, 32'h0);
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        tick(4);
        next_pop("fe_next_data", 8'h11);
        chk("fe_other_pulses", (ov_n - ov_base) + (pe_n - pe_base), 0);

        // Fill and overrun
        snap();
        rx_ready = 1'b0;
        send_frame(8'h01, 1'b1, 1'b0, 1'b0);
        send_frame(8'h02, 1'b1, 1'b0, 1'b0);
        send_frame(8'h03, 1'b1, 1'b0, 1'b0);
        send_frame(8'h04, 1'b1, 1'b0, 1'b0);
        tick(4);
        chk("fill_count", {29'h0, rx_count}, 32'd4);
        chk("fill_no_ovr", ov_n - ov_base, 0);
        chk("fill_head", {24'h0, rx_data}, 32'h01);
        send_frame(8'h05, 1'b1, 1'b0, 1'b0);
        tick(4);
        chk("ovr_pulses", ov_n - ov_base, 1);
        chk("ovr_count", {29'h0, rx_count}, 32'd4);
        chk("ovr_head", {24'h0, rx_data}, 32'h01);
        rx_ready = 1'b1;
        tick(6);
        rx_ready = 1'b0;
        next_pop("drain0", 8'h01);
        next_pop("drain1", 8'h02);
        next_pop("drain2", 8'h03);
        next_pop("drain3", 8'h04);
        chk("drain_count", {29'h0, rx_count}, 32'h0);
        chk("drain_hold", {24'h0, rx_data}, 32'h04);
        chk("drain_pops", pop_n, 6);

        // Full FIFO, pop coincides with stop sample of 0x77
        send_frame(8'h10, 1'b1, 1'b0, 1'b0);
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        send_frame(8'h12, 1'b1, 1'b0, 1'b0);
        send_frame(8'h13, 1'b1, 1'b0, 1'b0);
        tick(4);
        snap();
        chk("full_count", {29'h0, rx_count}, 32'd4);
        send_frame(8'h77, 1'b1, 1'b0, 1'b1);
        tick(4);
        chk("race_no_ovr", ov_n - ov_base, 0);
        chk("race_count", {29'h0, rx_count}, 32'd4);
        next_pop("race_pop", 8'h10);
        rx_ready = 1'b1;
        tick(8);
        next_pop("race_d1", 8'h11);
        next_pop("race_d2", 8'h12);
        next_pop("race_d3", 8'h13);
        next_pop("race_last", 8'h77);
        chk("empty_pop_count", {29'h0, rx_count}, 32'h0);
        chk("empty_pop_hold", {24'h0, rx_data}, 32'h77);
        rx_ready = 1'b0;

        // Reset mid-DATA of 0xFF with one byte buffered
        send_frame(8'h42, 1'b1, 1'b0, 1'b0);
        tick(4);
        chk("pre_rst_count", {29'h0, rx_count}, 32'd1);
        snap();
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(1);
        chk("mid_rst_count", {29'h0, rx_count}, 32'h0);
        chk("mid_rst_valid", {31'h0, rx_valid}, 32'h0);
        chk("mid_rst_data", {24'h0, rx_data}, 32'h0);
        tick(200);
        chk("mid_rst_quiet", {29'h0, rx_count}, 32'h0);
        chk("mid_rst_nopulse", (fe_n - fe_base) + (ov_n - ov_base) + (pe_n - pe_base), 0);
        rx_ready = 1'b1;
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        tick(4);
        next_pop("post_rst_data", 8'h5A);
        chk("post_rst_count", {29'h0, rx_count}, 32'h0);

`ifdef UART_RX_PARITY_EN
        snap();
        send_frame(8'h01, 1'b1, 1'b1, 1'b0);
        tick(4);
        chk("par_bad_pulse", pe_n - pe_base, 1);
        chk("par_bad_count", {29'h0, rx_count}, 32'h0);
        chk("par_bad_pops", pop_n, rd_idx);
        send_frame(8'h01, 1'b1, 1'b0, 1'b0);
        tick(4);
        next_pop("par_good_data", 8'h01);
        chk("par_good_pulse", pe_n - pe_base, 1);
`else
        chk("par_tied_low", pe_n, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
